// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg
//   Shared widths, "no operation" codes and the EX->MEM payload record used by
//   data_memory_pipe_reg and its testbench.
package riscv_pipe_pkg;

   localparam int unsigned DATA_W       = 32;  // ALU result width
   localparam int unsigned REG_ADD_W    = 5;   // rd address width
   localparam int unsigned D_CACHE_LW_W = 3;   // load-type code width
   localparam int unsigned D_CACHE_SW_W = 2;   // store-type code width
   localparam int unsigned STALL_CNT_W  = 16;  // back-pressure counter width

   localparam logic [D_CACHE_LW_W-1:0] LOAD_NONE  = '0;
   localparam logic [D_CACHE_SW_W-1:0] STORE_NONE = '0;

   typedef struct packed {
      logic [REG_ADD_W-1:0]    rd;
      logic [DATA_W-1:0]       alu;
      logic [D_CACHE_LW_W-1:0] load;
      logic [D_CACHE_SW_W-1:0] store;
      logic                    wb_sel;
      logic                    rd_we;
   } mem_stage_payload_t;

endpackage

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer
//   Generic 2-slot elastic buffer: a main slot that drives the outputs and a
//   skid slot that catches the one entry accepted while the main slot is
//   blocked. in_ready comes straight from a register, so there is no
//   combinational path from out_ready to in_ready.
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   flush          synchronous: empties both slots, drops the offered entry
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
module pipe_skid_buffer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             main_valid;
   logic [WIDTH-1:0] main_data;
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             accept;
   logic             drain;

   assign in_ready  = ~skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign accept    = in_valid & in_ready;
   assign drain     = main_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (flush) begin
         // payload registers deliberately hold their contents
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         // skid full implies in_ready=0, so only a drain can happen here
         if (drain) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
         end
      end else if (accept && (!main_valid || drain)) begin
         main_data  <= in_data;
         main_valid <= 1'b1;
      end else if (accept) begin
         skid_data  <= in_data;
         skid_valid <= 1'b1;
      end else if (drain) begin
         main_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/data_memory_pipe_reg.sv
// data_memory_pipe_reg
//   Elastic EX->MEM pipeline register. Packs rd address, ALU result,
//   load/store codes, write-back select and rd write enable into one payload,
//   carries it through a 2-slot skid buffer and gates the side-effecting
//   outputs (load, store, rd write) with OUT_VALID so bubbles are harmless.
// Ports
//   CLK, RST                clock (rising edge), async active-high reset
//   FLUSH                   synchronous flush, kills all held entries
//   IN_VALID / IN_READY     upstream handshake (IN_READY registered)
//   *_IN                    EX-stage payload fields
//   OUT_VALID / OUT_READY   downstream handshake towards MEM
//   *_OUT                   MEM-stage payload fields
//   STALL_COUNT             cycles with OUT_VALID=1 and OUT_READY=0, saturating
//                           (present only when DATA_MEMORY_PIPE_REG_STALL_CNT_EN
//                           is defined)
module data_memory_pipe_reg
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = DATA_W,
   parameter int unsigned REG_ADD_WIDTH    = REG_ADD_W,
   parameter int unsigned D_CACHE_LW_WIDTH = D_CACHE_LW_W,
   parameter int unsigned D_CACHE_SW_WIDTH = D_CACHE_SW_W,
   parameter int unsigned STALL_CNT_WIDTH  = STALL_CNT_W
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        FLUSH,
   input  logic                        IN_VALID,
   output logic                        IN_READY,
   input  logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_IN,
   input  logic [DATA_WIDTH-1:0]       ALU_OUT_IN,
   input  logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_IN,
   input  logic [D_CACHE_SW_WIDTH-1:0] DATA_CACHE_STORE_IN,
   input  logic                        WRITE_BACK_MUX_SELECT_IN,
   input  logic                        RD_WRITE_ENABLE_IN,
   output logic                        OUT_VALID,
   input  logic                        OUT_READY,
   output logic [REG_ADD_WIDTH-1:0]    RD_ADDRESS_OUT,
   output logic [DATA_WIDTH-1:0]       ALU_OUT_OUT,
   output logic [D_CACHE_LW_WIDTH-1:0] DATA_CACHE_LOAD_OUT,
   output logic [D_CACHE_SW_WIDTH-1:0] DATA_CACHE_STORE_OUT,
   output logic                        WRITE_BACK_MUX_SELECT_OUT,
   output logic                        RD_WRITE_ENABLE_OUT
`ifdef DATA_MEMORY_PIPE_REG_STALL_CNT_EN
   ,
   output logic [STALL_CNT_WIDTH-1:0]  STALL_COUNT
`endif
);

   mem_stage_payload_t pay_in;
   mem_stage_payload_t pay_out;

   assign pay_in = '{rd:     RD_ADDRESS_IN,
                     alu:    ALU_OUT_IN,
                     load:   DATA_CACHE_LOAD_IN,
                     store:  DATA_CACHE_STORE_IN,
                     wb_sel: WRITE_BACK_MUX_SELECT_IN,
                     rd_we:  RD_WRITE_ENABLE_IN};

   pipe_skid_buffer #(
      .WIDTH ($bits(mem_stage_payload_t))
   ) u_skid (
      .clk       (CLK),
      .rst       (RST),
      .flush     (FLUSH),
      .in_valid  (IN_VALID),
      .in_ready  (IN_READY),
      .in_data   (pay_in),
      .out_valid (OUT_VALID),
      .out_ready (OUT_READY),
      .out_data  (pay_out)
   );

   assign RD_ADDRESS_OUT            = pay_out.rd;
   assign ALU_OUT_OUT               = pay_out.alu;
   assign WRITE_BACK_MUX_SELECT_OUT = pay_out.wb_sel;
   // bubbles must never load, store or write rd
   assign DATA_CACHE_LOAD_OUT  = OUT_VALID ? pay_out.load  : LOAD_NONE;
   assign DATA_CACHE_STORE_OUT = OUT_VALID ? pay_out.store : STORE_NONE;
   assign RD_WRITE_ENABLE_OUT  = OUT_VALID & pay_out.rd_we;

`ifdef DATA_MEMORY_PIPE_REG_STALL_CNT_EN
   localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = 1;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         STALL_COUNT <= '0;
      end else if (OUT_VALID && !OUT_READY && (STALL_COUNT != '1)) begin
         STALL_COUNT <= STALL_COUNT + STALL_ONE;
      end
   end
`else
   logic unused_stall_cfg;
   assign unused_stall_cfg = (STALL_CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_data_memory_pipe_reg.sv
// tb_data_memory_pipe_reg
//   Scoreboard bench: accepted entries are queued when driven and compared
//   against the MEM-side outputs at each falling edge. Build with
//   DATA_MEMORY_PIPE_REG_STALL_CNT_EN defined to also cover the stall counter.
module tb_data_memory_pipe_reg;
   import riscv_pipe_pkg::*;

   localparam int unsigned SCW = 4;

   logic                    CLK = 1'b0;
   logic                    RST;
   logic                    FLUSH;
   logic                    IN_VALID;
   logic                    IN_READY;
   logic [REG_ADD_W-1:0]    RD_ADDRESS_IN;
   logic [DATA_W-1:0]       ALU_OUT_IN;
   logic [D_CACHE_LW_W-1:0] DATA_CACHE_LOAD_IN;
   logic [D_CACHE_SW_W-1:0] DATA_CACHE_STORE_IN;
   logic                    WRITE_BACK_MUX_SELECT_IN;
   logic                    RD_WRITE_ENABLE_IN;
   logic                    OUT_VALID;
   logic                    OUT_READY;
   logic [REG_ADD_W-1:0]    RD_ADDRESS_OUT;
   logic [DATA_W-1:0]       ALU_OUT_OUT;
   logic [D_CACHE_LW_W-1:0] DATA_CACHE_LOAD_OUT;
   logic [D_CACHE_SW_W-1:0] DATA_CACHE_STORE_OUT;
   logic                    WRITE_BACK_MUX_SELECT_OUT;
   logic                    RD_WRITE_ENABLE_OUT;
`ifdef DATA_MEMORY_PIPE_REG_STALL_CNT_EN
   logic [SCW-1:0]          STALL_COUNT;
`endif

   always #5 CLK = ~CLK;

   data_memory_pipe_reg #(
      .DATA_WIDTH       (DATA_W),
      .REG_ADD_WIDTH    (REG_ADD_W),
      .D_CACHE_LW_WIDTH (D_CACHE_LW_W),
      .D_CACHE_SW_WIDTH (D_CACHE_SW_W),
      .STALL_CNT_WIDTH  (SCW)
   ) dut (
      .CLK                       (CLK),
      .RST                       (RST),
      .FLUSH                     (FLUSH),
      .IN_VALID                  (IN_VALID),
      .IN_READY                  (IN_READY),
      .RD_ADDRESS_IN             (RD_ADDRESS_IN),
      .ALU_OUT_IN                (ALU_OUT_IN),
      .DATA_CACHE_LOAD_IN        (DATA_CACHE_LOAD_IN),
      .DATA_CACHE_STORE_IN       (DATA_CACHE_STORE_IN),
      .WRITE_BACK_MUX_SELECT_IN  (WRITE_BACK_MUX_SELECT_IN),
      .RD_WRITE_ENABLE_IN        (RD_WRITE_ENABLE_IN),
      .OUT_VALID                 (OUT_VALID),
      .OUT_READY                 (OUT_READY),
      .RD_ADDRESS_OUT            (RD_ADDRESS_OUT),
      .ALU_OUT_OUT               (ALU_OUT_OUT),
      .DATA_CACHE_LOAD_OUT       (DATA_CACHE_LOAD_OUT),
      .DATA_CACHE_STORE_OUT      (DATA_CACHE_STORE_OUT),
      .WRITE_BACK_MUX_SELECT_OUT (WRITE_BACK_MUX_SELECT_OUT),
      .RD_WRITE_ENABLE_OUT       (RD_WRITE_ENABLE_OUT)
`ifdef DATA_MEMORY_PIPE_REG_STALL_CNT_EN
      ,
      .STALL_COUNT               (STALL_COUNT)
`endif
   );

   int unsigned        n_tests = 0;
   int unsigned        n_fails = 0;
   mem_stage_payload_t sb_q[$];
   int unsigned        exp_stall = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // payload fields are derived from the ALU value so one number identifies an entry
   function automatic mem_stage_payload_t make_payload(input logic [DATA_W-1:0] v);
      mem_stage_payload_t p;
      p.alu    = v;
      p.rd     = v[4:0];
      p.load   = v[7:5];
      p.store  = v[9:8];
      p.wb_sel = v[10];
      p.rd_we  = v[11];
      return p;
   endfunction

   task automatic check_outputs();
      logic exp_valid;
      exp_valid = (sb_q.size() > 0);
      check("out_valid", OUT_VALID, exp_valid);
      check("in_ready", IN_READY, sb_q.size() < 2);
      if (exp_valid) begin
         check("alu_out", ALU_OUT_OUT, sb_q[0].alu);
         check("rd_addr", RD_ADDRESS_OUT, sb_q[0].rd);
         check("load_out", DATA_CACHE_LOAD_OUT, sb_q[0].load);
         check("store_out", DATA_CACHE_STORE_OUT, sb_q[0].store);
         check("wb_sel", WRITE_BACK_MUX_SELECT_OUT, sb_q[0].wb_sel);
         check("rd_we", RD_WRITE_ENABLE_OUT, sb_q[0].rd_we);
      end else begin
         check("bubble_load", DATA_CACHE_LOAD_OUT, '0);
         check("bubble_store", DATA_CACHE_STORE_OUT, '0);
         check("bubble_rd_we", RD_WRITE_ENABLE_OUT, 1'b0);
      end
`ifdef DATA_MEMORY_PIPE_REG_STALL_CNT_EN
      check("stall_count", STALL_COUNT, exp_stall);
`endif
   endtask

   // called at a falling edge: check, drive, advance the model, wait one cycle
   task automatic step(input logic iv, input logic [DATA_W-1:0] v, input logic ordy, input logic fl);
      mem_stage_payload_t p;
      logic acc, drn;
      check_outputs();
      p = make_payload(v);
      IN_VALID                 = iv;
      OUT_READY                = ordy;
      FLUSH                    = fl;
      ALU_OUT_IN               = p.alu;
      RD_ADDRESS_IN            = p.rd;
      DATA_CACHE_LOAD_IN       = p.load;
      DATA_CACHE_STORE_IN      = p.store;
      WRITE_BACK_MUX_SELECT_IN = p.wb_sel;
      RD_WRITE_ENABLE_IN       = p.rd_we;
      if (sb_q.size() > 0 && !ordy && exp_stall < (1 << SCW) - 1) exp_stall++;
      acc = iv && (sb_q.size() < 2);
      drn = (sb_q.size() > 0) && ordy;
      if (fl) begin
         sb_q.delete();
      end else begin
         if (drn) void'(sb_q.pop_front());
         if (acc) sb_q.push_back(p);
      end
      @(negedge CLK);
   endtask

   initial begin
      RST = 1'b1;
      FLUSH = 1'b0;
      IN_VALID = 1'b0;
      OUT_READY = 1'b0;
      ALU_OUT_IN = '0;
      RD_ADDRESS_IN = '0;
      DATA_CACHE_LOAD_IN = '0;
      DATA_CACHE_STORE_IN = '0;
      WRITE_BACK_MUX_SELECT_IN = 1'b0;
      RD_WRITE_ENABLE_IN = 1'b0;
      @(negedge CLK);
      // reset state
      check("rst_out_valid", OUT_VALID, 1'b0);
      check("rst_in_ready", IN_READY, 1'b1);
      check("rst_alu", ALU_OUT_OUT, '0);
      RST = 1'b0;
      @(negedge CLK);

      // streaming 1..8, then one idle cycle to drain
      for (int unsigned i = 1; i <= 8; i++) step(1'b1, i, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // back-pressure: A into main, B into skid, C refused, then drain
      step(1'b1, 32'h0000_0ABC, 1'b0, 1'b0);
      step(1'b1, 32'h0000_05F3, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0C11, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b1, 32'h0000_0D22, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // flush with both slots full and an entry offered
      step(1'b1, 32'h0000_0B01, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0A02, 1'b0, 1'b0);
      step(1'b1, 32'h0000_DEAD, 1'b0, 1'b1);
      check("flush_out_valid", OUT_VALID, 1'b0);
      check("flush_store", DATA_CACHE_STORE_OUT, '0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // bubble gating: rd_we=1, store=2'b10 offered with IN_VALID=0
      step(1'b0, 32'h0000_0A00, 1'b1, 1'b0);
      check("gate_rd_we", RD_WRITE_ENABLE_OUT, 1'b0);
      check("gate_store", DATA_CACHE_STORE_OUT, '0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // random traffic
      for (int unsigned i = 0; i < 200; i++)
         step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

      // asynchronous reset mid-stream
      step(1'b1, 32'h0000_0F0F, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0E0E, 1'b0, 1'b0);
      #2;
      RST = 1'b1;
      #1;
      check("arst_out_valid", OUT_VALID, 1'b0);
      check("arst_rd_we", RD_WRITE_ENABLE_OUT, 1'b0);
      check("arst_in_ready", IN_READY, 1'b1);
      check("arst_alu", ALU_OUT_OUT, '0);
      sb_q.delete();
      exp_stall = 0;
      @(negedge CLK);
      RST = 1'b0;
      IN_VALID = 1'b0;
      @(negedge CLK);
      check("post_rst_in_ready", IN_READY, 1'b1);
      step(1'b1, 32'h0000_0123, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef DATA_MEMORY_PIPE_REG_STALL_CNT_EN
      // stall counter saturation and reset clear
      step(1'b1, 32'h0000_0777, 1'b0, 1'b0);
      for (int unsigned i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
      check("stall_saturated", STALL_COUNT, 4'hF);
      RST = 1'b1;
      #1;
      check("stall_rst", STALL_COUNT, '0);
      sb_q.delete();
      exp_stall = 0;
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      step(1'b0, 32'h0, 1'b1, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
